// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and helpers for the hex display scanner and its refresh divider.
package hex_display_scanner_pkg;

  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam int         NIBBLE_W   = 4;
  localparam int         NUM_DIGITS = 4;
  localparam logic [1:0] LAST_IDX   = 2'd3;

  // True when every nibble at or above position k is zero (digit k is a leading zero).
  function automatic logic upper_zero(input logic [15:0] v, input int k);
    return (v >> (NIBBLE_W * k)) == 16'h0000;
  endfunction

endpackage

// File: rtl/hex_display_scanner_tick_gen.sv
// Refresh divider: emits a one-cycle tick every REFRESH_DIV clocks, marking the end of a digit slot.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign tick = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexes a 16-bit value onto a shared 4-bit digit bus with active-low anodes,
// committing new values only at frame boundaries and optionally blanking leading zeros.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        load_ack
);

  logic                  tick;
  logic                  boundary;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           disp_q, disp_d;
  logic [15:0]           pending_q, pending_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            digit_q, digit_d;
  logic [3:0]            anode_q, anode_d;
  logic                  ack_q, ack_d;
  logic [NUM_DIGITS-1:0] blank_mask;

  refresh_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .DIV_W       (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign boundary = tick && (idx_q == LAST_IDX);

  // A load landing on the boundary bypasses the pending buffer and supersedes it.
  always_comb begin
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    disp_d     = disp_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (load) begin
        disp_d = value;
        ack_d  = 1'b1;
      end else if (pend_vld_q) begin
        disp_d = pending_q;
        ack_d  = 1'b1;
      end
    end else if (load) begin
      pending_d  = value;
      pend_vld_d = 1'b1;
    end
  end

  assign blank_mask[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
    assign blank_mask[gi] = blank_lz & upper_zero(disp_d, gi);
  end

  always_comb begin
    digit_d = disp_d[NIBBLE_W * idx_d +: NIBBLE_W];
    anode_d = ~(4'b0001 << idx_d);
    if (blank_mask[idx_d]) begin
      anode_d = ANODE_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= 2'd0;
      disp_q     <= 16'h0000;
      pending_q  <= 16'h0000;
      pend_vld_q <= 1'b0;
      digit_q    <= 4'h0;
      anode_q    <= ANODE_OFF;
      ack_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      digit_q    <= digit_d;
      anode_q    <= anode_d;
      ack_q      <= ack_d;
    end
  end

  assign digit    = digit_q;
  assign anode    = anode_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with a 4-cycle digit slot (16-cycle frame).
module tb_hex_display_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        load_ack;

  int total;
  int bad;

  hex_display_scanner #(
    .REFRESH_DIV (4),
    .DIV_W       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .digit    (digit),
    .anode    (anode),
    .load_ack (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges; on return the next edge is edge 1 after release.
  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'hFFFF;
    blank_lz = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (anode !== 4'b1111) begin
        $display("FAIL reset_anode cyc=%0d got=%b want=1111", c, anode); bad++;
      end
      total++;
      if (digit !== 4'h0) begin
        $display("FAIL reset_digit cyc=%0d got=%h want=0", c, digit); bad++;
      end
      total++;
      if (load_ack !== 1'b0) begin
        $display("FAIL reset_ack cyc=%0d got=%b want=0", c, load_ack); bad++;
      end
      total++;
    end
    $display("test_reset done");
  endtask

  // Load 1234 on edge 1; commit at edge 16, then scan 4/3/2/1.
  task automatic test_scan();
    logic [15:0] shown;
    logic [3:0]  want_a;
    logic [3:0]  want_d;
    int          k;
    do_reset();
    value = 16'h1234;
    load  = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      load   = 1'b0;
      k      = (e / 4) % 4;
      shown  = (e >= 16) ? 16'h1234 : 16'h0000;
      want_a = ~(4'b0001 << k);
      want_d = shown[k*4 +: 4];
      if (anode !== want_a) begin
        $display("FAIL scan_anode e=%0d got=%b want=%b", e, anode, want_a); bad++;
      end
      total++;
      if (digit !== want_d) begin
        $display("FAIL scan_digit e=%0d got=%h want=%h", e, digit, want_d); bad++;
      end
      total++;
      if (load_ack !== (e == 16)) begin
        $display("FAIL scan_ack e=%0d got=%b want=%b", e, load_ack, (e == 16)); bad++;
      end
      total++;
    end
    $display("test_scan done");
  endtask

  task automatic test_blanking();
    logic [3:0] a50 [4];
    logic [3:0] d50 [4];
    logic [3:0] a00 [4];
    int         k;
    a50[0] = 4'b1110; a50[1] = 4'b1101; a50[2] = 4'b1111; a50[3] = 4'b1111;
    d50[0] = 4'h0;    d50[1] = 4'h5;    d50[2] = 4'h0;    d50[3] = 4'h0;
    a00[0] = 4'b1110; a00[1] = 4'b1111; a00[2] = 4'b1111; a00[3] = 4'b1111;
    do_reset();
    blank_lz = 1'b1;
    value    = 16'h0050;
    load     = 1'b1;
    for (int e = 1; e <= 47; e++) begin
      step();
      load = 1'b0;
      k    = (e / 4) % 4;
      if (e == 19) begin
        value = 16'h0000;
        load  = 1'b1;
      end
      if (e >= 16 && e < 32) begin
        if (anode !== a50[k]) begin
          $display("FAIL blank50_anode e=%0d got=%b want=%b", e, anode, a50[k]); bad++;
        end
        total++;
        if (digit !== d50[k]) begin
          $display("FAIL blank50_digit e=%0d got=%h want=%h", e, digit, d50[k]); bad++;
        end
        total++;
      end else begin
        if (anode !== a00[k]) begin
          $display("FAIL blank00_anode e=%0d got=%b want=%b", e, anode, a00[k]); bad++;
        end
        total++;
        if (digit !== 4'h0) begin
          $display("FAIL blank00_digit e=%0d got=%h want=0", e, digit); bad++;
        end
        total++;
      end
      if (load_ack !== (e == 16 || e == 32)) begin
        $display("FAIL blank_ack e=%0d got=%b want=%b", e, load_ack, (e == 16 || e == 32)); bad++;
      end
      total++;
    end
    blank_lz = 1'b0;
    $display("test_blanking done");
  endtask

  // Two mid-frame loads: latest wins, single ack.
  task automatic test_overwrite();
    logic [15:0] beef;
    int          acks;
    int          k;
    beef = 16'hBEEF;
    acks = 0;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      load  = (e == 5 || e == 9);
      value = (e == 5) ? 16'hAAAA : 16'hBEEF;
      step();
      load = 1'b0;
      k    = (e / 4) % 4;
      if (load_ack === 1'b1) acks++;
      if (e >= 16 && digit !== beef[k*4 +: 4]) begin
        $display("FAIL overwrite_digit e=%0d got=%h want=%h", e, digit, beef[k*4 +: 4]); bad++;
      end
      if (e >= 16) total++;
    end
    if (acks != 1) begin
      $display("FAIL overwrite_ack_count got=%0d want=1", acks); bad++;
    end
    total++;
    $display("test_overwrite done");
  endtask

  // C0DE loaded on the boundary cycle replaces pending 1111.
  task automatic test_boundary_load();
    logic [15:0] code;
    int          acks;
    int          k;
    code = 16'hC0DE;
    acks = 0;
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      load  = (e == 3 || e == 16);
      value = (e == 3) ? 16'h1111 : 16'hC0DE;
      step();
      load = 1'b0;
      k    = (e / 4) % 4;
      if (load_ack === 1'b1) acks++;
      if (e == 16 && load_ack !== 1'b1) begin
        $display("FAIL bypass_ack_edge got=%b want=1", load_ack); bad++;
      end
      if (e == 16) total++;
      if (e >= 16 && digit !== code[k*4 +: 4]) begin
        $display("FAIL bypass_digit e=%0d got=%h want=%h", e, digit, code[k*4 +: 4]); bad++;
      end
      if (e >= 16) total++;
    end
    if (acks != 1) begin
      $display("FAIL bypass_ack_count got=%0d want=1", acks); bad++;
    end
    total++;
    $display("test_boundary_load done");
  endtask

  // Reset mid-scan with a pending value: pending discarded, no ack, display back to 0000.
  task automatic test_reset_midscan();
    int acks;
    int k;
    acks = 0;
    do_reset();
    value = 16'h5678;
    for (int e = 1; e <= 9; e++) begin
      load = (e == 2);
      step();
      load = 1'b0;
    end
    reset = 1'b1;
    step();
    if (anode !== 4'b1111) begin
      $display("FAIL midreset_anode got=%b want=1111", anode); bad++;
    end
    total++;
    if (load_ack !== 1'b0) begin
      $display("FAIL midreset_ack got=%b want=0", load_ack); bad++;
    end
    total++;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 36; e++) begin
      step();
      k = (e / 4) % 4;
      if (load_ack === 1'b1) acks++;
      if (anode !== ~(4'b0001 << k)) begin
        $display("FAIL midreset_scan_anode e=%0d got=%b want=%b", e, anode, ~(4'b0001 << k)); bad++;
      end
      total++;
      if (digit !== 4'h0) begin
        $display("FAIL midreset_scan_digit e=%0d got=%h want=0", e, digit); bad++;
      end
      total++;
    end
    if (acks != 0) begin
      $display("FAIL midreset_ack_count got=%0d want=0", acks); bad++;
    end
    total++;
    $display("test_reset_midscan done");
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_blanking();
    test_overwrite();
    test_boundary_load();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
